// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets and STATUS bit layout.
package uart_pkg;

  typedef enum logic [1:0] {
    TxIdle  = 2'd0,
    TxStart = 2'd1,
    TxData  = 2'd2,
    TxStop  = 2'd3
  } TxState;

  localparam logic [1:0] OffTxData  = 2'd0;
  localparam logic [1:0] OffStatus  = 2'd1;
  localparam logic [1:0] OffDivisor = 2'd2;

  localparam int unsigned StFullBit  = 0;
  localparam int unsigned StEmptyBit = 1;
  localparam int unsigned StOvfBit   = 2;
  localparam int unsigned StCountLsb = 8;

  function automatic logic [31:0] status_word(input logic [7:0] count,
                                              input logic       ovf,
                                              input logic       empty,
                                              input logic       full);
    logic [31:0] w;
    w                    = '0;
    w[StCountLsb +: 8]   = count;
    w[StOvfBit]          = ovf;
    w[StEmptyBit]        = empty;
    w[StFullBit]         = full;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// Synchronous first-word-fall-through FIFO; push while full and pop while
// empty are ignored, so callers may request either unconditionally.
module fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers/count alone.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, register file, registered
// read port, TX FIFO and the baud-timed serialiser.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [29:0] BASE       = 30'h3FFF_FFF0,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd867
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] bus_addr,
  input  logic [31:0] bus_data_w,
  input  logic [3:0]  bus_mask_w,
  output logic [31:0] bus_data_r,
  output logic        bus_hit,
  output logic        uart_tx
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic        hit, wr;
  logic [1:0]  off;
  logic        push_req, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_dout, count8;
  logic [CW-1:0] fifo_count;

  logic        ovf_q, ovf_d;
  logic [15:0] div_q, div_d;
  logic [31:0] rdata_q, rdata_d;
  logic        hit_q;

  TxState      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic        tx_q, tx_d;
  logic        bit_end;
  logic        unused_bits;

  assign hit         = (bus_addr[29:2] == BASE[29:2]);
  assign off         = bus_addr[1:0];
  assign wr          = |bus_mask_w;
  assign push_req    = hit & (off == OffTxData) & bus_mask_w[0];
  assign count8      = 8'(fifo_count);
  assign unused_bits = ^{bus_data_w[31:16], bus_mask_w[3:2]};

  fifo_sync #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (bus_data_w[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A rejected push flags overflow even if the serialiser pops this cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (push_req && fifo_full) begin
      ovf_d = 1'b1;
    end else if (hit && (off == OffStatus) && bus_mask_w[0] && bus_data_w[StOvfBit]) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    div_d = div_q;
    if (hit && (off == OffDivisor)) begin
      if (bus_mask_w[0]) div_d[7:0]  = bus_data_w[7:0];
      if (bus_mask_w[1]) div_d[15:8] = bus_data_w[15:8];
    end
  end

  always_comb begin
    rdata_d = '0;
    if (hit && !wr) begin
      case (off)
        OffStatus:  rdata_d = status_word(count8, ovf_q, fifo_empty, fifo_full);
        OffDivisor: rdata_d = {16'h0000, div_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  assign bit_end = (cnt_q == '0);

  // Each bit lasts div+1 clocks; the divisor is only sampled at reloads.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    fifo_pop = 1'b0;
    case (state_q)
      TxIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          cnt_d    = div_q;
          state_d  = TxStart;
        end
      end
      TxStart: begin
        if (bit_end) begin
          cnt_d   = div_q;
          bit_d   = '0;
          state_d = TxData;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TxData: begin
        if (bit_end) begin
          cnt_d   = div_q;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = TxStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      TxStop: begin
        if (bit_end) begin
          state_d = TxIdle;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
    endcase

    case (state_d)
      TxStart: tx_d = 1'b0;
      TxData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_q   <= 1'b0;
      div_q   <= DIV_RESET;
      rdata_q <= '0;
      hit_q   <= 1'b0;
      state_q <= TxIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      ovf_q   <= ovf_d;
      div_q   <= div_d;
      rdata_q <= rdata_d;
      hit_q   <= hit;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  assign bus_data_r = rdata_q;
  assign bus_hit    = hit_q;
  assign uart_tx    = tx_q;

endmodule
